// File: rtl/timer_multi.sv
`default_nettype none
// ============================================================================
// Module   : timer_multi
// Purpose  : CHANNELS independent WIDTH-bit down-counters with prescalers,
//            cascade, compare output and underflow/compare IRQs on a byte bus.
// Revision : 1.0 - initial release
// ============================================================================
module timer_multi #(
    parameter int          CHANNELS  = 2,
    parameter int          WIDTH     = 16,
    parameter logic [23:0] BASE_ADDR = 24'h2030
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clk_ce,
    input  logic                clk_rt_ce,
    input  logic                bus_write,
    input  logic                bus_read,
    input  logic [23:0]         bus_address_in,
    input  logic [7:0]          bus_data_in,
    output logic [7:0]          bus_data_out,
    output logic [CHANNELS-1:0] irq_underflow,
    output logic [CHANNELS-1:0] irq_compare,
    output logic [CHANNELS-1:0] tout,
    output logic                osc256
);

    localparam logic [23:0] c_SPAN = 24'(8 * CHANNELS);

    logic [11:0] r_osc1;
    logic [6:0]  r_osc2;
    logic [7:0]  w_osc1_tick;
    logic [23:0] w_offs;
    logic        w_hit;
    logic [7:0]  w_rd [CHANNELS];
    logic        w_unused;

    assign w_unused = bus_read;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_osc1 <= '0;
            r_osc2 <= '0;
        end else begin
            if (clk_ce)    r_osc1 <= r_osc1 + 12'd1;
            if (clk_rt_ce) r_osc2 <= r_osc2 + 7'd1;
        end
    end

    // Divider taps for osc1: low k bits all ones, k = 1,3,5,6,7,8,10,12
    assign w_osc1_tick = {8{clk_ce}} & {&r_osc1[11:0], &r_osc1[9:0], &r_osc1[7:0], &r_osc1[6:0],
                                        &r_osc1[5:0], &r_osc1[4:0], &r_osc1[2:0], r_osc1[0]};
    assign osc256 = clk_rt_ce & (&r_osc2);

    assign w_offs = bus_address_in - BASE_ADDR;
    assign w_hit  = (w_offs < c_SPAN);

    always_comb begin
        bus_data_out = '0;
        for (int i = 0; i < CHANNELS; i++) bus_data_out = bus_data_out | w_rd[i];
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic             w_sel, w_we, w_reload, w_evt, w_uf, w_cm, w_tick, w_presc_tick;
        logic [5:0]       w_wr;
        logic [6:0]       w_mask;
        logic [7:0]       w_rdata;
        logic [15:0]      w_preset16, w_cmp16, w_cnt16, w_preset_nx, w_cmp_nx;
        logic             r_en, r_os, r_casc, r_osel;
        logic [2:0]       r_ps;
        logic             r_fuf, r_fcmp, r_tout, r_irq_uf, r_irq_cmp;
        logic [WIDTH-1:0] r_preset, r_cmp, r_cnt;

        assign w_sel = w_hit && (w_offs[5:3] == 3'(i));
        assign w_we  = bus_write && w_sel;

        always_comb begin
            w_wr = '0;
            for (int r = 0; r < 6; r++) w_wr[r] = w_we && (w_offs[2:0] == 3'(r));
        end

        assign w_preset16  = 16'(r_preset);
        assign w_cmp16     = 16'(r_cmp);
        assign w_cnt16     = 16'(r_cnt);
        assign w_preset_nx = w_wr[2] ? {w_preset16[15:8], bus_data_in} : {bus_data_in, w_preset16[7:0]};
        assign w_cmp_nx    = w_wr[4] ? {w_cmp16[15:8], bus_data_in} : {bus_data_in, w_cmp16[7:0]};

        assign w_mask       = 7'((8'd1 << r_ps) - 8'd1);
        assign w_presc_tick = r_osel ? (clk_rt_ce && ((r_osc2 & w_mask) == w_mask)) : w_osc1_tick[r_ps];

        if (i == 0) begin : g_first
            assign w_tick = w_presc_tick;
        end else begin : g_casc
            // Cascade ticks on the previous channel's underflow in the same cycle
            assign w_tick = r_casc ? g_ch[i-1].w_uf : w_presc_tick;
        end

        assign w_reload = w_wr[0] && bus_data_in[1];
        assign w_evt    = w_tick && r_en && !w_reload;
        assign w_uf     = w_evt && (r_cnt == '0);
        assign w_cm     = w_evt && (r_cnt == r_cmp);

        always_ff @(posedge clk) begin
            if (reset) begin
                r_en      <= 1'b0;
                r_os      <= 1'b0;
                r_casc    <= 1'b0;
                r_osel    <= 1'b0;
                r_ps      <= '0;
                r_fuf     <= 1'b0;
                r_fcmp    <= 1'b0;
                r_tout    <= 1'b0;
                r_irq_uf  <= 1'b0;
                r_irq_cmp <= 1'b0;
                r_preset  <= '0;
                r_cmp     <= '0;
                r_cnt     <= '0;
            end else begin
                r_irq_uf  <= w_uf;
                r_irq_cmp <= w_cm;
                if (w_wr[0]) begin
                    r_en   <= bus_data_in[0];
                    r_os   <= bus_data_in[2];
                    r_casc <= bus_data_in[3];
                    r_osel <= bus_data_in[4];
                    r_ps   <= bus_data_in[7:5];
                end
                if (w_uf && r_os) r_en <= 1'b0;
                r_fuf  <= (r_fuf  & ~(w_wr[1] & bus_data_in[0])) | w_uf;
                r_fcmp <= (r_fcmp & ~(w_wr[1] & bus_data_in[1])) | w_cm;
                if (w_wr[2] || w_wr[3]) r_preset <= w_preset_nx[WIDTH-1:0];
                if (w_wr[4] || w_wr[5]) r_cmp    <= w_cmp_nx[WIDTH-1:0];
                if (w_reload || w_uf)   r_cnt    <= r_preset;
                else if (w_evt)         r_cnt    <= r_cnt - WIDTH'(1);
                if (w_cm)               r_tout   <= 1'b0;
                else if (w_uf)          r_tout   <= 1'b1;
            end
        end

        always_comb begin
            w_rdata = '0;
            if (w_sel) begin
                case (w_offs[2:0])
                    3'd0: w_rdata = {r_ps, r_osel, r_casc, r_os, 1'b0, r_en};
                    3'd1: w_rdata = {6'd0, r_fcmp, r_fuf};
                    3'd2: w_rdata = w_preset16[7:0];
                    3'd3: w_rdata = w_preset16[15:8];
                    3'd4: w_rdata = w_cmp16[7:0];
                    3'd5: w_rdata = w_cmp16[15:8];
                    3'd6: w_rdata = w_cnt16[7:0];
                    3'd7: w_rdata = w_cnt16[15:8];
                endcase
            end
        end

        assign w_rd[i]          = w_rdata;
        assign irq_underflow[i] = r_irq_uf;
        assign irq_compare[i]   = r_irq_cmp;
        assign tout[i]          = r_tout;
    end

endmodule
`default_nettype wire

// File: tb/tb_timer_multi.sv
`default_nettype none
// Bench for timer_multi: behavioural model with per-cycle compare, directed
// literal checks, randomized bus traffic and a WIDTH=8 instance.
module tb_timer_multi;
    localparam int          CH   = 2;
    localparam logic [23:0] BASE = 24'h2030;
    localparam int          KT [8] = '{1, 3, 5, 6, 7, 8, 10, 12};

    logic          clk = 1'b0;
    logic          reset, clk_ce, clk_rt_ce, bus_write, bus_read;
    logic [23:0]   bus_address_in;
    logic [7:0]    bus_data_in, bus_data_out;
    logic [CH-1:0] irq_underflow, irq_compare, tout;
    logic          osc256;

    logic          rt8, w8, osc256_8;
    logic [23:0]   a8;
    logic [7:0]    d8, dout8;
    logic [0:0]    uf8, cm8, tout8;

    always #5 clk = ~clk;

    timer_multi #(.CHANNELS(CH), .WIDTH(16), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .clk_ce(clk_ce), .clk_rt_ce(clk_rt_ce),
        .bus_write(bus_write), .bus_read(bus_read), .bus_address_in(bus_address_in),
        .bus_data_in(bus_data_in), .bus_data_out(bus_data_out),
        .irq_underflow(irq_underflow), .irq_compare(irq_compare), .tout(tout), .osc256(osc256));

    timer_multi #(.CHANNELS(1), .WIDTH(8), .BASE_ADDR(BASE)) dut8 (
        .clk(clk), .reset(reset), .clk_ce(clk_ce), .clk_rt_ce(rt8),
        .bus_write(w8), .bus_read(1'b0), .bus_address_in(a8),
        .bus_data_in(d8), .bus_data_out(dout8),
        .irq_underflow(uf8), .irq_compare(cm8), .tout(tout8), .osc256(osc256_8));

    int checks = 0;
    int errors = 0;

    // Model state: plain integers per channel
    int m_osc1, m_osc2;
    int m_en[CH], m_os[CH], m_casc[CH], m_osel[CH], m_ps[CH];
    int m_fuf[CH], m_fcmp[CH], m_preset[CH], m_cmp[CH], m_cnt[CH];
    int m_tout[CH], m_iuf[CH], m_icm[CH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_osc1 = 0;
        m_osc2 = 0;
        for (int c = 0; c < CH; c++) begin
            m_en[c] = 0; m_os[c] = 0; m_casc[c] = 0; m_osel[c] = 0; m_ps[c] = 0;
            m_fuf[c] = 0; m_fcmp[c] = 0; m_preset[c] = 0; m_cmp[c] = 0; m_cnt[c] = 0;
            m_tout[c] = 0; m_iuf[c] = 0; m_icm[c] = 0;
        end
    endtask

    function automatic int m_read(input logic [23:0] a);
        int off, c;
        if (a < BASE || int'(a) >= int'(BASE) + 8 * CH) return 0;
        off = int'(a) - int'(BASE);
        c   = off / 8;
        case (off % 8)
            0: return m_en[c] + 4 * m_os[c] + 8 * m_casc[c] + 16 * m_osel[c] + 32 * m_ps[c];
            1: return m_fuf[c] + 2 * m_fcmp[c];
            2: return m_preset[c] % 256;
            3: return m_preset[c] / 256;
            4: return m_cmp[c] % 256;
            5: return m_cmp[c] / 256;
            6: return m_cnt[c] % 256;
            default: return m_cnt[c] / 256;
        endcase
    endfunction

    // Advance the model across one clock edge using the inputs now applied
    task automatic model_step();
        int  off, wr_ch, wr_reg, tick, prev_uf, uf, cm, os_old, per;
        bit  wr, reload;
        if (reset) begin
            model_reset();
            return;
        end
        off    = int'(bus_address_in) - int'(BASE);
        wr     = bus_write && off >= 0 && off < 8 * CH;
        wr_ch  = wr ? off / 8 : -1;
        wr_reg = wr ? off % 8 : -1;
        prev_uf = 0;
        for (int c = 0; c < CH; c++) begin
            reload = (wr_ch == c) && (wr_reg == 0) && bus_data_in[1];
            if (c > 0 && m_casc[c] != 0) tick = prev_uf;
            else if (m_osel[c] != 0) begin
                per  = 1 << m_ps[c];
                tick = int'(clk_rt_ce && (m_osc2 % per) == per - 1);
            end else begin
                per  = 1 << KT[m_ps[c]];
                tick = int'(clk_ce && (m_osc1 % per) == per - 1);
            end
            tick = int'(tick != 0 && m_en[c] != 0 && !reload);
            uf = int'(tick != 0 && m_cnt[c] == 0);
            cm = int'(tick != 0 && m_cnt[c] == m_cmp[c]);
            prev_uf = uf;
            os_old  = m_os[c];
            if (reload || uf != 0) m_cnt[c] = m_preset[c];
            else if (tick != 0)    m_cnt[c] = m_cnt[c] - 1;
            if (cm != 0)      m_tout[c] = 0;
            else if (uf != 0) m_tout[c] = 1;
            if (wr_ch == c && wr_reg == 1) begin
                if (bus_data_in[0]) m_fuf[c]  = 0;
                if (bus_data_in[1]) m_fcmp[c] = 0;
            end
            if (uf != 0) m_fuf[c]  = 1;
            if (cm != 0) m_fcmp[c] = 1;
            m_iuf[c] = uf;
            m_icm[c] = cm;
            if (wr_ch == c) begin
                case (wr_reg)
                    0: begin
                        m_en[c] = int'(bus_data_in[0]); m_os[c] = int'(bus_data_in[2]);
                        m_casc[c] = int'(bus_data_in[3]); m_osel[c] = int'(bus_data_in[4]);
                        m_ps[c] = int'(bus_data_in[7:5]);
                    end
                    2: m_preset[c] = (m_preset[c] & 'hFF00) | int'(bus_data_in);
                    3: m_preset[c] = (m_preset[c] & 'h00FF) | (int'(bus_data_in) << 8);
                    4: m_cmp[c]    = (m_cmp[c] & 'hFF00) | int'(bus_data_in);
                    5: m_cmp[c]    = (m_cmp[c] & 'h00FF) | (int'(bus_data_in) << 8);
                    default: ;
                endcase
            end
            if (uf != 0 && os_old != 0) m_en[c] = 0;
        end
        if (clk_ce)    m_osc1 = (m_osc1 + 1) % 4096;
        if (clk_rt_ce) m_osc2 = (m_osc2 + 1) % 128;
    endtask

    task automatic compare_all();
        for (int c = 0; c < CH; c++) begin
            chk("irq_underflow", irq_underflow[c], m_iuf[c]);
            chk("irq_compare", irq_compare[c], m_icm[c]);
            chk("tout", tout[c], m_tout[c]);
        end
        chk("osc256", osc256, clk_rt_ce && m_osc2 == 127);
        chk("bus_data_out", bus_data_out, m_read(bus_address_in));
    endtask

    // One clock: compare on the falling edge, then step the model over the rising edge
    task automatic cyc();
        @(negedge clk);
        compare_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [23:0] a, input logic [7:0] d);
        bus_address_in = a;
        bus_data_in    = d;
        bus_write      = 1'b1;
        cyc();
        bus_write      = 1'b0;
    endtask

    task automatic read_all_zero(input string name);
        for (int a = 0; a < 8 * CH; a++) begin
            bus_address_in = BASE + 24'(a);
            #1;
            chk(name, bus_data_out, 0);
            cyc();
        end
        chk({name, "_tout"}, tout, 0);
        chk({name, "_irq"}, {irq_underflow, irq_compare}, 0);
    endtask

    initial begin
        int n, u0, u1, bad, off, last_osc, prev_irq, n8, bad8;
        logic [7:0] d;
        reset = 1'b1; clk_ce = 1'b0; clk_rt_ce = 1'b0; bus_write = 1'b0; bus_read = 1'b0;
        bus_address_in = BASE; bus_data_in = 8'd0;
        rt8 = 1'b0; w8 = 1'b0; a8 = BASE; d8 = 8'd0;
        @(posedge clk);
        #1;
        model_reset();
        cyc();
        reset = 1'b0;
        cyc();
        read_all_zero("reset_read");

        // Ch0 count sequence 3,2,1,0,3 with a tick every 2 cycles
        wr(BASE + 24'd2, 8'd3);
        wr(BASE + 24'd4, 8'd1);
        clk_ce = 1'b1;
        wr(BASE, 8'h03);
        bus_address_in = BASE + 24'd6;
        #1;
        chk("seq_cnt3", bus_data_out, 3);
        cyc();
        chk("seq_cnt2", bus_data_out, 2);
        cyc(); cyc();
        chk("seq_cnt1", bus_data_out, 1);
        cyc(); cyc();
        chk("seq_cnt0", bus_data_out, 0);
        chk("seq_irq_cmp", irq_compare, 2'b01);
        chk("seq_tout_lo", tout, 2'b00);
        cyc(); cyc();
        chk("seq_reload", bus_data_out, 3);
        chk("seq_irq_uf", irq_underflow, 2'b01);
        chk("seq_tout_hi", tout, 2'b01);
        cyc();
        chk("seq_irq_width", irq_underflow, 2'b00);

        // One-shot
        wr(BASE + 24'd1, 8'h03);
        wr(BASE + 24'd2, 8'd2);
        wr(BASE, 8'h07);
        n = 0;
        repeat (20) begin
            cyc();
            if (irq_underflow[0]) n++;
        end
        chk("oneshot_pulses", n, 1);
        bus_address_in = BASE;
        #1;
        chk("oneshot_enable", bus_data_out[0], 0);
        bus_address_in = BASE + 24'd6;
        #1;
        chk("oneshot_count", bus_data_out, 2);

        // Cascade: ch0 underflows every tick, ch1 every second ch0 underflow
        wr(BASE + 24'd2, 8'd0);
        wr(BASE + 24'd10, 8'd1);
        wr(BASE + 24'd8, 8'h0B);
        wr(BASE, 8'h03);
        u0 = 0; u1 = 0; bad = 0;
        repeat (40) begin
            cyc();
            if (irq_underflow[0]) u0++;
            if (irq_underflow[1]) begin
                u1++;
                if (!irq_underflow[0]) bad++;
            end
        end
        chk("casc_uf0", u0, 20);
        chk("casc_uf1", u1, 10);
        chk("casc_same_cycle", bad, 0);

        // Status clear in the same cycle as an underflow: set wins
        for (int t = 0; t < 4 && (m_osc1 % 2) == 0; t++) cyc();
        wr(BASE + 24'd1, 8'h01);
        #1;
        chk("status_set_wins", bus_data_out[0], 1);
        clk_ce = 1'b0;
        wr(BASE + 24'd1, 8'h01);
        #1;
        chk("status_cleared", bus_data_out[0], 0);

        // Reset mid-count
        clk_ce = 1'b1;
        repeat (3) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        read_all_zero("midreset_read");

        // Randomized traffic against the model
        repeat (3000) begin
            reset          = ($urandom_range(999) == 0);
            clk_ce         = ($urandom_range(3) != 0);
            clk_rt_ce      = ($urandom_range(2) == 0);
            bus_read       = 1'($urandom_range(1));
            bus_address_in = BASE - 24'd4 + 24'($urandom_range(8 * CH + 7));
            bus_write      = ($urandom_range(5) == 0);
            d   = 8'($urandom_range(255));
            off = int'(bus_address_in) - int'(BASE);
            if (off >= 0) begin
                case (off % 8)
                    0: d = {3'($urandom_range(2)), d[4:3], ($urandom_range(3) == 0), d[1], ($urandom_range(4) != 0)};
                    2, 4: d = 8'($urandom_range(6));
                    3, 5: if ($urandom_range(7) != 0) d = 8'd0;
                    default: ;
                endcase
            end
            bus_data_in = d;
            cyc();
        end
        reset = 1'b0;
        bus_write = 1'b0;

        // WIDTH=8 instance: bits above WIDTH, osc2 p=7 period
        a8 = BASE + 24'd3; d8 = 8'hFF; w8 = 1'b1;
        @(posedge clk); #1;
        w8 = 1'b0;
        chk("w8_preset_h", dout8, 0);
        a8 = BASE; d8 = 8'hF3; w8 = 1'b1;
        @(posedge clk); #1;
        w8 = 1'b0;
        last_osc = -1; prev_irq = -1; n8 = 0; bad8 = 0;
        for (int cy = 0; cy < 1700; cy++) begin
            rt8 = (cy % 4 == 0);
            #1;
            if (osc256_8) last_osc = cy;
            @(posedge clk); #1;
            if (uf8[0]) begin
                n8++;
                if (last_osc != cy) bad8++;
                if (prev_irq >= 0 && cy - prev_irq != 512) bad8++;
                prev_irq = cy;
            end
        end
        rt8 = 1'b0;
        chk("w8_tick_count", n8, 3);
        chk("w8_tick_timing", bad8, 0);
        chk("w8_first_tick", prev_irq, 1532);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
